// File: rtl/dsel_pkg.sv
// Shared defaults and entry layout for the dsel write buffer.
// The default widths match the upstream dsel stage.
package dsel_pkg;
    localparam int DSEL_AWIDTH = 32;
    localparam int DSEL_DWIDTH = 32;
    localparam int DSEL_DEPTH  = 8;

    typedef struct packed {
        logic [DSEL_AWIDTH-1:0] addr;
        logic [DSEL_DWIDTH-1:0] data;
    } dsel_entry_t;
endpackage

// File: rtl/dsel_wbuf_if.sv
// Producer/consumer bundle for the dsel write buffer.
// The master side drives writes and consumes the head entry; the slave side is the buffer.
interface dsel_wbuf_if
    import dsel_pkg::*;
#(
    parameter int AWIDTH = DSEL_AWIDTH,
    parameter int DWIDTH = DSEL_DWIDTH,
    parameter int DEPTH  = DSEL_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wbuf_in_en;
    logic [AWIDTH-1:0] wbuf_in_addr;
    logic [DWIDTH-1:0] wbuf_in;
    logic              wbuf_out_valid;
    logic              wbuf_out_ready;
    logic [AWIDTH-1:0] wbuf_out_addr;
    logic [DWIDTH-1:0] wbuf_out;
    logic [CW-1:0]     wbuf_count;
    logic              wbuf_full;
    logic              wbuf_ovf;
    logic              wbuf_ovf_clr;

    modport master (
        output wbuf_in_en, wbuf_in_addr, wbuf_in, wbuf_out_ready, wbuf_ovf_clr,
        input  wbuf_out_valid, wbuf_out_addr, wbuf_out, wbuf_count, wbuf_full, wbuf_ovf
    );

    modport slave (
        input  wbuf_in_en, wbuf_in_addr, wbuf_in, wbuf_out_ready, wbuf_ovf_clr,
        output wbuf_out_valid, wbuf_out_addr, wbuf_out, wbuf_count, wbuf_full, wbuf_ovf
    );
endinterface

// File: rtl/dsel_wbuf_mem.sv
// Entry storage for the write buffer.
// It has one write port and one asynchronous read port, and its contents are not reset.
module dsel_wbuf_mem #(
    parameter int W     = 64,
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [PW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dsel_wbuf.sv
// Show-ahead write buffer between the dsel stage and its consumer.
// It drops writes that arrive when the buffer is full and records each drop in a sticky overflow flag.
module dsel_wbuf
    import dsel_pkg::*;
#(
    parameter int AWIDTH = DSEL_AWIDTH,
    parameter int DWIDTH = DSEL_DWIDTH,
    parameter int DEPTH  = DSEL_DEPTH
) (
    input logic         clk,
    input logic         rst,
    dsel_wbuf_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int W  = AWIDTH + DWIDTH;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [W-1:0]  w_rdata;

    // Control depends only on the counter and the strobes, never on storage contents.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = !w_empty && bus.wbuf_out_ready;
    assign w_push  = bus.wbuf_in_en && (!w_full || w_pop);
    assign w_drop  = bus.wbuf_in_en && w_full && !w_pop;

    dsel_wbuf_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata ({bus.wbuf_in_addr, bus.wbuf_in}),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            // A new drop wins over a clear in the same cycle.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.wbuf_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.wbuf_out_valid = !w_empty;
    assign bus.wbuf_out_addr  = w_rdata[W-1:DWIDTH];
    assign bus.wbuf_out       = w_rdata[DWIDTH-1:0];
    assign bus.wbuf_count     = r_count;
    assign bus.wbuf_full      = w_full;
    assign bus.wbuf_ovf       = r_ovf;
endmodule

// File: tb/tb_dsel_wbuf.sv
// Bench for dsel_wbuf: a queue-based reference model is compared against the DUT every cycle.
// Directed scenarios carry literal expectations, and a randomized phase follows them.
module tb_dsel_wbuf;
    import dsel_pkg::*;

    localparam int AW = DSEL_AWIDTH;
    localparam int DW = DSEL_DWIDTH;
    localparam int DP = DSEL_DEPTH;

    logic clk;
    logic rst;
    dsel_wbuf_if #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DP)) bus ();

    dsel_wbuf #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    dsel_entry_t q[$];
    bit m_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is an ordered list of entries plus a sticky flag.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            bit pop;
            bit drop;
            dsel_entry_t e;
            pop  = (q.size() > 0) && bus.wbuf_out_ready;
            drop = bus.wbuf_in_en && (q.size() == DP) && !pop;
            if (drop) m_ovf = 1'b1;
            else if (bus.wbuf_ovf_clr) m_ovf = 1'b0;
            if (pop) void'(q.pop_front());
            if (bus.wbuf_in_en && !drop) begin
                e.addr = bus.wbuf_in_addr;
                e.data = bus.wbuf_in;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 64'(bus.wbuf_out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("head", 64'({bus.wbuf_out_addr, bus.wbuf_out}), 64'(q[0]));
            end
            chk("count", 64'(bus.wbuf_count), 64'(q.size()));
            chk("full", 64'(bus.wbuf_full), 64'(q.size() == DP));
            chk("ovf", 64'(bus.wbuf_ovf), 64'(m_ovf));
        end
    end

    task automatic cyc(input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit rdy, input bit clr, input bit r);
        bus.wbuf_in_en     = en;
        bus.wbuf_in_addr   = a;
        bus.wbuf_in        = d;
        bus.wbuf_out_ready = rdy;
        bus.wbuf_ovf_clr   = clr;
        rst                = r;
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) cyc(1'b1, AW'(32'h100 + i), DW'(base + i), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.wbuf_in_en = 1'b0; bus.wbuf_in_addr = '0; bus.wbuf_in = '0;
        bus.wbuf_out_ready = 1'b0; bus.wbuf_ovf_clr = 1'b0;
        rst = 1'b1;
        cyc(1'b1, '0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("rst_valid", 64'(bus.wbuf_out_valid), 64'd0);
        chk("rst_count", 64'(bus.wbuf_count), 64'd0);
        chk("rst_full", 64'(bus.wbuf_full), 64'd0);
        chk("rst_ovf", 64'(bus.wbuf_ovf), 64'd0);

        // Single push, then a pop on the following edge.
        cyc(1'b1, AW'(32'h10), DW'(32'hA5A5_0001), 1'b1, 1'b0, 1'b0);
        chk("single_valid", 64'(bus.wbuf_out_valid), 64'd1);
        chk("single_addr", 64'(bus.wbuf_out_addr), 64'h10);
        chk("single_data", 64'(bus.wbuf_out), 64'hA5A5_0001);
        chk("single_cnt1", 64'(bus.wbuf_count), 64'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("single_cnt0", 64'(bus.wbuf_count), 64'd0);

        // Fill to full, overflow, then clear-versus-drop priority.
        fill(8, 1);
        chk("fill_full", 64'(bus.wbuf_full), 64'd1);
        chk("fill_count", 64'(bus.wbuf_count), 64'd8);
        cyc(1'b1, AW'(32'h200), DW'(9), 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 64'(bus.wbuf_ovf), 64'd1);
        chk("ovf_count", 64'(bus.wbuf_count), 64'd8);
        cyc(1'b1, AW'(32'h201), DW'(10), 1'b0, 1'b1, 1'b0);
        chk("ovf_clr_drop", 64'(bus.wbuf_ovf), 64'd1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", 64'(bus.wbuf_ovf), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 64'(bus.wbuf_out), 64'(i));
            cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 64'(bus.wbuf_out_valid), 64'd0);

        // Push and pop on the same edge while full.
        fill(8, 1);
        cyc(1'b1, AW'(32'h300), DW'(9), 1'b1, 1'b0, 1'b0);
        chk("fullpp_count", 64'(bus.wbuf_count), 64'd8);
        chk("fullpp_ovf", 64'(bus.wbuf_ovf), 64'd0);
        chk("fullpp_head", 64'(bus.wbuf_out), 64'd2);
        for (int i = 2; i <= 9; i++) begin
            chk("fullpp_drain", 64'(bus.wbuf_out), 64'(i));
            cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end

        // Streaming push and pop across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                chk("stream_data", 64'(bus.wbuf_out), 64'(i - 1));
                chk("stream_count", 64'(bus.wbuf_count), 64'd1);
            end
            cyc(1'b1, AW'(32'h400 + i), DW'(i), 1'b1, 1'b0, 1'b0);
        end
        chk("stream_last", 64'(bus.wbuf_out), 64'd19);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Reset with traffic pending.
        fill(8, 50);
        cyc(1'b1, '0, DW'(99), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(bus.wbuf_count), 64'd5);
        cyc(1'b1, AW'(32'h500), DW'(77), 1'b1, 1'b1, 1'b1);
        chk("rst_mid_count", 64'(bus.wbuf_count), 64'd0);
        chk("rst_mid_valid", 64'(bus.wbuf_out_valid), 64'd0);
        chk("rst_mid_ovf", 64'(bus.wbuf_ovf), 64'd0);
        cyc(1'b1, AW'(32'h600), DW'(32'hCAFE_0001), 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", 64'(bus.wbuf_out), 64'hCAFE_0001);
        chk("post_rst_count", 64'(bus.wbuf_count), 64'd1);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), AW'($urandom), DW'($urandom),
                1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5),
                1'($urandom_range(0, 999) < 4));
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
